bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that sits directly upstream of the per-digit seven-segment lookup on the DE1-SoC HEX displays. It takes an unsigned binary value, produces DIGITS packed BCD nibbles, and drives one lookup instance per digit with them. It also provides a leading-zero blank mask for the display top level and saturates on overflow. Conversion uses one iteration per input bit under a start/done handshake.

---
 rtl/bin2bcd_pkg.sv | 21 ++
 rtl/bin2bcd_seq_add3.sv | 13 +
 rtl/bin2bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Controller states: wait for a request, iterate once per input bit, publish.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic longint unsigned max_val(input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Nibble adjust for double dabble: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  // Inputs never exceed 9 on a valid path, so the sum fits in 4 bits.
  always_comb begin
    out_nib = (in_nib >= 4'd5) ? (in_nib + 4'd3) : in_nib;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per
// input bit, start/done handshake, leading-zero blank mask and saturation.
//
// Handshake: iSTART is only honoured in IDLE, and iBIN is captured on that
// same edge. oBUSY is high for exactly WIDTH cycles, then oDONE pulses for one
// cycle with oBCD/oBLANK/oOVF updated on the same edge; those outputs hold
// until the next oDONE. Requests arriving while busy or done are dropped.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [WIDTH-1:0]      iBIN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic [DIGITS-1:0]     oBLANK,
  output logic                  oOVF,
  output logic [1:0]            oDBG_STATE
);

  localparam int SW = 4 * DIGITS;          // BCD scratch width
  localparam int RW = SW + WIDTH;          // full shift register width
  localparam int CW = $clog2(WIDTH + 1);   // iteration counter width
  localparam longint unsigned MAXV = max_val(DIGITS);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     sr_q, sr_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovf_out_q, ovf_out_d;

  logic [SW-1:0]     scratch_adj;
  logic [RW-1:0]     sr_shift;
  logic [SW-1:0]     bcd_new;
  logic [DIGITS-1:0] blank_new;
  logic              zero_above;
  logic              ovf_in;
  logic              last_iter;

  // Per-digit +3 adjust on the pre-shift scratch nibbles.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .in_nib  (sr_q[WIDTH + 4*g +: 4]),
      .out_nib (scratch_adj[4*g +: 4])
    );
  end

  // Shift the adjusted register left by one; the top scratch bit falls off,
  // which only happens for saturating inputs whose result is replaced anyway.
  always_comb begin
    sr_shift = RW'({scratch_adj, sr_q[WIDTH-1:0], 1'b0});
  end

  // Overflow test on the raw input and end-of-iteration detect.
  always_comb begin
    ovf_in    = (64'(iBIN) > MAXV);
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Result to publish and its leading-zero blank mask (digit 0 never blanks).
  always_comb begin
    bcd_new    = ovf_q ? {DIGITS{4'h9}} : sr_q[RW-1:WIDTH];
    blank_new  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above && (bcd_new[4*i +: 4] == 4'h0);
      blank_new[i] = zero_above;
    end
  end

  // State register plus datapath flops; reset discards any in-flight work.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (iSTART) state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output updates for each state.
  always_comb begin
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    busy_d    = (state_d == ST_SHIFT);
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          sr_d  = {{SW{1'b0}}, iBIN};
          ovf_d = ovf_in;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
      end
      ST_DONE: begin
        bcd_d     = bcd_new;
        blank_d   = blank_new;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_comb begin
    oBUSY      = busy_q;
    oDONE      = done_q;
    oBCD       = bcd_q;
    oBLANK     = blank_q;
    oOVF       = ovf_out_q;
    oDBG_STATE = state_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed scenarios plus randomized conversions
// checked against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = WIDTH + 1;
  localparam logic [DIGITS-1:0] BLANK_RST = 6'b111110;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              busy;
  logic              done;
  logic [W-1:0]      bcd;
  logic [DIGITS-1:0] blank;
  logic              ovf;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iSTART     (start),
    .iBIN       (bin),
    .oBUSY      (busy),
    .oDONE      (done),
    .oBCD       (bcd),
    .oBLANK     (blank),
    .oOVF       (ovf),
    .oDBG_STATE (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: decimal digits by repeated division, saturated at 999999.
  function automatic logic [W-1:0] model_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = (v > 999999) ? 999999 : v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: digits at or above the significant-digit count blank.
  function automatic logic [DIGITS-1:0] model_blank(input int unsigned v);
    logic [DIGITS-1:0] m;
    int unsigned t;
    int nd;
    t  = (v > 999999) ? 999999 : v;
    nd = 1;
    while (t >= 10) begin
      t = t / 10;
      nd++;
    end
    m = '0;
    for (int i = 1; i < DIGITS; i++) m[i] = (i >= nd);
    return m;
  endfunction

  // Driver: one-cycle start pulse, then wait (bounded) for done.
  task automatic run_conv(input logic [WIDTH-1:0] v, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin    = WIDTH'($urandom);
    lat    = -1;
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: busy=%b done=%b, required 0/0", busy, done);
      end
      checks++;
      if (bcd !== '0 || blank !== BLANK_RST || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_data: bcd=%h blank=%b ovf=%b, required 000000/%b/0", bcd, blank, ovf, BLANK_RST);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bn;
    logic [W-1:0] held;
    run_conv(20'd123456, lat, bn);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, LAT);
    end
    checks++;
    if (bn != WIDTH) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required %0d", bn, WIDTH);
    end
    checks++;
    if (bcd !== 24'h123456 || blank !== 6'b000000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: bcd=%h blank=%b ovf=%b, required 123456/000000/0", bcd, blank, ovf);
    end
    held = bcd;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd !== held) begin
      errors++;
      $display("FAIL basic_pulse_hold: done=%b busy=%b bcd=%h, required 0/0/%h", done, busy, bcd, held);
    end
  endtask

  task automatic test_zero_42();
    int lat, bn;
    run_conv(20'd0, lat, bn);
    checks++;
    if (lat != LAT || bcd !== 24'h000000 || blank !== 6'b111110 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero: lat=%0d bcd=%h blank=%b ovf=%b, required %0d/000000/111110/0", lat, bcd, blank, ovf, LAT);
    end
    run_conv(20'd42, lat, bn);
    checks++;
    if (lat != LAT || bcd !== 24'h000042 || blank !== 6'b111100 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL forty_two: lat=%0d bcd=%h blank=%b ovf=%b, required %0d/000042/111100/0", lat, bcd, blank, ovf, LAT);
    end
  endtask

  task automatic test_boundaries();
    int unsigned vals[3] = '{999999, 1000000, 1048575};
    int lat, bn;
    logic exp_ovf;
    for (int i = 0; i < 3; i++) begin
      run_conv(WIDTH'(vals[i]), lat, bn);
      exp_ovf = (vals[i] > 999999);
      checks++;
      if (lat != LAT || bcd !== 24'h999999 || blank !== 6'b000000 || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL boundary_%0d: lat=%0d bcd=%h blank=%b ovf=%b, required %0d/999999/000000/%b",
                 vals[i], lat, bcd, blank, ovf, LAT, exp_ovf);
      end
    end
  endtask

  task automatic test_random();
    int lat, bn;
    int unsigned v;
    logic [W-1:0] exp_bcd;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(999000, 1048575);
        default: v = $urandom_range(0, 1048575);
      endcase
      exp_q.push_back(model_bcd(v));
      run_conv(WIDTH'(v), lat, bn);
      exp_bcd = exp_q.pop_front();
      checks++;
      if (lat != LAT || bcd !== exp_bcd || blank !== model_blank(v) || ovf !== (v > 999999)) begin
        errors++;
        $display("FAIL random_%0d: lat=%0d bcd=%h blank=%b ovf=%b, required %0d/%h/%b/%b",
                 v, lat, bcd, blank, ovf, LAT, exp_bcd, model_blank(v), (v > 999999));
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int lat = -1;
    logic [W-1:0] got = '0;
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd555;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1;
        bin   = 20'd7;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k - 1;
          got = bcd;
        end
      end
    end
    checks++;
    if (ndone != 1 || lat != LAT || got !== 24'h000555) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d lat=%0d bcd=%h, required 1/%0d/000555", ndone, lat, got, LAT);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bn;
    int ndone = 0;
    run_conv(20'd1000001, lat, bn);
    checks++;
    if (ovf !== 1'b1 || bcd !== 24'h999999) begin
      errors++;
      $display("FAIL pre_reset_ovf: bcd=%h ovf=%b, required 999999/1", bcd, ovf);
    end
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd555;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 10) rst = 1'b1;
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || blank !== BLANK_RST || ovf !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_state: busy=%b done=%b bcd=%h blank=%b ovf=%b, required 0/0/000000/%b/0",
                   busy, done, bcd, blank, ovf, BLANK_RST);
        end
        rst = 1'b0;
      end
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: dones=%0d, required 0", ndone);
    end
    run_conv(20'd2024, lat, bn);
    checks++;
    if (lat != LAT || bn != WIDTH || bcd !== 24'h002024 || blank !== 6'b110000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_conv: lat=%0d busy=%0d bcd=%h blank=%b ovf=%b, required %0d/%0d/002024/110000/0",
               lat, bn, bcd, blank, ovf, LAT, WIDTH);
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    int k = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 20'd314159;
    while (times.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
      if (done) begin
        times.push_back(k);
        checks++;
        if (bcd !== 24'h314159 || blank !== 6'b000000 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result: bcd=%h blank=%b ovf=%b, required 314159/000000/0", bcd, blank, ovf);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (times.size() != 3) begin
      errors++;
      $display("FAIL b2b_timeout: dones=%0d, required 3", times.size());
    end else begin
      checks++;
      if (times[0] != LAT + 1 || times[1] - times[0] != WIDTH + 2 || times[2] - times[1] != WIDTH + 2) begin
        errors++;
        $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d, required %0d/%0d,%0d",
                 times[0], times[1] - times[0], times[2] - times[1], LAT + 1, WIDTH + 2, WIDTH + 2);
      end
    end
    repeat (WIDTH + 4) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_zero_42();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
